// File: rtl/dcmac_stat_pkg.sv
// rtl/dcmac_stat_pkg.sv - shared widths, popcount helper and counter triple type for the AXIS stats counter
package dcmac_stat_pkg;

    localparam int MAX_SEG   = 64;
    localparam int MAX_CNT_W = 64;

    function automatic int f_id_w(input int num_id);
        return (num_id == 1) ? 1 : $clog2(num_id);
    endfunction

    function automatic int f_pkt_inc_w(input int num_seg);
        return $clog2(num_seg + 1);
    endfunction

    function automatic int f_popcnt(input logic [MAX_SEG-1:0] v);
        int c;
        c = 0;
        for (int k = 0; k < MAX_SEG; k++) begin
            c += int'(v[k]);
        end
        return c;
    endfunction

    // Counters narrower than MAX_CNT_W are zero-extended into this type.
    typedef struct packed {
        logic [MAX_CNT_W-1:0] pkt_cnt;
        logic [MAX_CNT_W-1:0] byte_cnt;
        logic [MAX_CNT_W-1:0] err_cnt;
    } cnt_triple_t;

endpackage

// File: rtl/dcmac_stat_acc.sv
// rtl/dcmac_stat_acc.sv - single statistics accumulator with wrap/saturate, restart-load and overflow event
module dcmac_stat_acc #(
    parameter int CNT_W    = 48,
    parameter int INC_W    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INC_W-1:0] i_inc,
    input  logic             i_load,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_ovf_evt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   sum;

    // Next count: a load restarts at the coincident increment, otherwise add with carry handling.
    always_comb begin
        sum       = {1'b0, cnt_q} + (CNT_W+1)'(i_inc);
        cnt_d     = cnt_q;
        o_ovf_evt = 1'b0;
        if (i_load) begin
            cnt_d = CNT_W'(i_inc);
        end else if (sum[CNT_W]) begin
            o_ovf_evt = 1'b1;
            cnt_d     = SATURATE ? '1 : sum[CNT_W-1:0];
        end else begin
            cnt_d = sum[CNT_W-1:0];
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/dcmac_axis_stat_cnt.sv
// rtl/dcmac_axis_stat_cnt.sv - per-channel packet/byte/error statistics with clear and snapshot
module dcmac_axis_stat_cnt
    import dcmac_stat_pkg::*;
#(
    parameter int NUM_ID         = 6,
    parameter int NUM_SEG        = 3,
    parameter int SIZE_W         = 8,
    parameter int CNT_W          = 48,
    parameter bit SATURATE       = 1'b0,
    parameter bit REGISTER_INPUT = 1'b1,
    localparam int ID_W          = f_id_w(NUM_ID),
    localparam int PKT_INC_W     = f_pkt_inc_w(NUM_SEG)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_vld,
    input  logic [ID_W-1:0]               i_id,
    input  logic [NUM_SEG-1:0]            i_eop,
    input  logic [NUM_SEG-1:0]            i_err,
    input  logic [SIZE_W-1:0]             i_size,
    input  logic [NUM_ID-1:0]             i_clear,
    input  logic [NUM_ID-1:0]             i_snap,
    output logic [NUM_ID-1:0][CNT_W-1:0]  o_pkt_cnt,
    output logic [NUM_ID-1:0][CNT_W-1:0]  o_byte_cnt,
    output logic [NUM_ID-1:0][CNT_W-1:0]  o_err_cnt,
    output logic [NUM_ID-1:0][CNT_W-1:0]  o_snap_pkt,
    output logic [NUM_ID-1:0][CNT_W-1:0]  o_snap_byte,
    output logic [NUM_ID-1:0][CNT_W-1:0]  o_snap_err,
    output logic [NUM_ID-1:0]             o_snap_vld,
    output logic [NUM_ID-1:0]             o_ovf
);

    // ---------------- stage A: optional input register ----------------
    logic               a_vld;
    logic [ID_W-1:0]    a_id;
    logic [NUM_SEG-1:0] a_eop;
    logic [NUM_SEG-1:0] a_err;
    logic [SIZE_W-1:0]  a_size;

    if (REGISTER_INPUT) begin : g_in_reg
        logic               a_vld_q;
        logic               a_vld_d;
        logic [ID_W-1:0]    a_id_q;
        logic [ID_W-1:0]    a_id_d;
        logic [NUM_SEG-1:0] a_eop_q;
        logic [NUM_SEG-1:0] a_eop_d;
        logic [NUM_SEG-1:0] a_err_q;
        logic [NUM_SEG-1:0] a_err_d;
        logic [SIZE_W-1:0]  a_size_q;
        logic [SIZE_W-1:0]  a_size_d;

        // Input capture.
        always_comb begin
            a_vld_d  = i_vld;
            a_id_d   = i_id;
            a_eop_d  = i_eop;
            a_err_d  = i_err;
            a_size_d = i_size;
        end

        // Input register; reset discards an in-flight beat.
        always_ff @(posedge clk) begin
            if (rst) begin
                a_vld_q  <= 1'b0;
                a_id_q   <= '0;
                a_eop_q  <= '0;
                a_err_q  <= '0;
                a_size_q <= '0;
            end else begin
                a_vld_q  <= a_vld_d;
                a_id_q   <= a_id_d;
                a_eop_q  <= a_eop_d;
                a_err_q  <= a_err_d;
                a_size_q <= a_size_d;
            end
        end

        assign a_vld  = a_vld_q;
        assign a_id   = a_id_q;
        assign a_eop  = a_eop_q;
        assign a_err  = a_err_q;
        assign a_size = a_size_q;
    end else begin : g_in_bypass
        assign a_vld  = i_vld;
        assign a_id   = i_id;
        assign a_eop  = i_eop;
        assign a_err  = i_err;
        assign a_size = i_size;
    end

    // ---------------- stage B: per-beat increments ----------------
    logic                 a_id_ok;
    logic                 b_vld_q;
    logic                 b_vld_d;
    logic [ID_W-1:0]      b_id_q;
    logic [ID_W-1:0]      b_id_d;
    logic [PKT_INC_W-1:0] b_pkt_inc_q;
    logic [PKT_INC_W-1:0] b_pkt_inc_d;
    logic [PKT_INC_W-1:0] b_err_inc_q;
    logic [PKT_INC_W-1:0] b_err_inc_d;
    logic [SIZE_W-1:0]    b_byte_inc_q;
    logic [SIZE_W-1:0]    b_byte_inc_d;

    // Increments are forced to zero for idle beats and out-of-range channels.
    always_comb begin
        a_id_ok      = a_vld && (int'(a_id) < NUM_ID);
        b_vld_d      = a_id_ok;
        b_id_d       = a_id;
        b_pkt_inc_d  = '0;
        b_err_inc_d  = '0;
        b_byte_inc_d = '0;
        if (a_id_ok) begin
            b_pkt_inc_d  = PKT_INC_W'(f_popcnt(MAX_SEG'(a_eop)));
            b_err_inc_d  = PKT_INC_W'(f_popcnt(MAX_SEG'(a_eop & a_err)));
            b_byte_inc_d = a_size;
        end
    end

    // Increment register.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_vld_q      <= 1'b0;
            b_id_q       <= '0;
            b_pkt_inc_q  <= '0;
            b_err_inc_q  <= '0;
            b_byte_inc_q <= '0;
        end else begin
            b_vld_q      <= b_vld_d;
            b_id_q       <= b_id_d;
            b_pkt_inc_q  <= b_pkt_inc_d;
            b_err_inc_q  <= b_err_inc_d;
            b_byte_inc_q <= b_byte_inc_d;
        end
    end

    // ---------------- stage C: per-channel control and accumulators ----------------
    logic [NUM_ID-1:0] clr1_q;
    logic [NUM_ID-1:0] clr1_d;
    logic [NUM_ID-1:0] clr2_q;
    logic [NUM_ID-1:0] clr2_d;
    logic [NUM_ID-1:0] clr_edge;
    logic [NUM_ID-1:0] snap_q;
    logic [NUM_ID-1:0] snap_d;
    logic [NUM_ID-1:0] snap_vld_q;
    logic [NUM_ID-1:0] snap_vld_d;
    logic [NUM_ID-1:0] ovf_q;
    logic [NUM_ID-1:0] ovf_d;
    logic [NUM_ID-1:0] ovf_evt;
    cnt_triple_t       snap_reg_q [NUM_ID];
    cnt_triple_t       snap_reg_d [NUM_ID];

    // Clear edge detect, snapshot capture of pre-update counts, sticky overflow.
    always_comb begin
        clr1_d     = i_clear;
        clr2_d     = clr1_q;
        clr_edge   = clr1_q & ~clr2_q;
        snap_d     = i_snap;
        snap_vld_d = snap_q;
        snap_reg_d = snap_reg_q;
        ovf_d      = ovf_q;
        for (int i = 0; i < NUM_ID; i++) begin
            ovf_d[i] = clr_edge[i] ? 1'b0 : (ovf_q[i] | ovf_evt[i]);
            if (snap_q[i]) begin
                snap_reg_d[i].pkt_cnt  = MAX_CNT_W'(o_pkt_cnt[i]);
                snap_reg_d[i].byte_cnt = MAX_CNT_W'(o_byte_cnt[i]);
                snap_reg_d[i].err_cnt  = MAX_CNT_W'(o_err_cnt[i]);
            end
        end
    end

    // Control and snapshot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr1_q     <= '0;
            clr2_q     <= '0;
            snap_q     <= '0;
            snap_vld_q <= '0;
            ovf_q      <= '0;
            snap_reg_q <= '{default: '0};
        end else begin
            clr1_q     <= clr1_d;
            clr2_q     <= clr2_d;
            snap_q     <= snap_d;
            snap_vld_q <= snap_vld_d;
            ovf_q      <= ovf_d;
            snap_reg_q <= snap_reg_d;
        end
    end

    for (genvar g = 0; g < NUM_ID; g++) begin : g_id
        logic                 hit;
        logic                 load;
        logic [PKT_INC_W-1:0] pkt_inc;
        logic [PKT_INC_W-1:0] err_inc;
        logic [SIZE_W-1:0]    byte_inc;
        logic                 pkt_evt;
        logic                 byte_evt;
        logic                 err_evt;

        assign hit      = b_vld_q && (b_id_q == ID_W'(g));
        assign load     = clr_edge[g] | snap_q[g];
        assign pkt_inc  = hit ? b_pkt_inc_q  : '0;
        assign err_inc  = hit ? b_err_inc_q  : '0;
        assign byte_inc = hit ? b_byte_inc_q : '0;

        dcmac_stat_acc #(.CNT_W(CNT_W), .INC_W(PKT_INC_W), .SATURATE(SATURATE)) u_pkt (
            .clk       (clk),
            .rst       (rst),
            .i_inc     (pkt_inc),
            .i_load    (load),
            .o_cnt     (o_pkt_cnt[g]),
            .o_ovf_evt (pkt_evt)
        );

        dcmac_stat_acc #(.CNT_W(CNT_W), .INC_W(SIZE_W), .SATURATE(SATURATE)) u_byte (
            .clk       (clk),
            .rst       (rst),
            .i_inc     (byte_inc),
            .i_load    (load),
            .o_cnt     (o_byte_cnt[g]),
            .o_ovf_evt (byte_evt)
        );

        dcmac_stat_acc #(.CNT_W(CNT_W), .INC_W(PKT_INC_W), .SATURATE(SATURATE)) u_err (
            .clk       (clk),
            .rst       (rst),
            .i_inc     (err_inc),
            .i_load    (load),
            .o_cnt     (o_err_cnt[g]),
            .o_ovf_evt (err_evt)
        );

        assign ovf_evt[g]     = pkt_evt | byte_evt | err_evt;
        assign o_snap_pkt[g]  = CNT_W'(snap_reg_q[g].pkt_cnt);
        assign o_snap_byte[g] = CNT_W'(snap_reg_q[g].byte_cnt);
        assign o_snap_err[g]  = CNT_W'(snap_reg_q[g].err_cnt);
    end

    assign o_snap_vld = snap_vld_q;
    assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_dcmac_axis_stat_cnt.sv
// tb/tb_dcmac_axis_stat_cnt.sv - directed self-checking bench for the AXIS statistics counter
module tb_dcmac_axis_stat_cnt;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // main instance: 6 channels, 48-bit wrap counters, registered input
    logic             m_vld;
    logic [2:0]       m_id;
    logic [2:0]       m_eop;
    logic [2:0]       m_err;
    logic [7:0]       m_size;
    logic [5:0]       m_clear;
    logic [5:0]       m_snap;
    logic [5:0][47:0] m_pkt;
    logic [5:0][47:0] m_byte;
    logic [5:0][47:0] m_errc;
    logic [5:0][47:0] m_spkt;
    logic [5:0][47:0] m_sbyte;
    logic [5:0][47:0] m_serr;
    logic [5:0]       m_svld;
    logic [5:0]       m_ovf;

    // two 16-bit instances sharing one stimulus: wrap (registered) and saturate (unregistered)
    logic             w_vld;
    logic [0:0]       w_id;
    logic [2:0]       w_eop;
    logic [2:0]       w_err;
    logic [7:0]       w_size;
    logic [1:0]       w_clear;
    logic [1:0]       w_snap;
    logic [1:0][15:0] a_pkt, a_byte, a_errc, a_spkt, a_sbyte, a_serr;
    logic [1:0]       a_svld, a_ovf;
    logic [1:0][15:0] s_pkt, s_byte, s_errc, s_spkt, s_sbyte, s_serr;
    logic [1:0]       s_svld, s_ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    dcmac_axis_stat_cnt u_main (
        .clk(clk), .rst(rst), .i_vld(m_vld), .i_id(m_id), .i_eop(m_eop), .i_err(m_err),
        .i_size(m_size), .i_clear(m_clear), .i_snap(m_snap),
        .o_pkt_cnt(m_pkt), .o_byte_cnt(m_byte), .o_err_cnt(m_errc),
        .o_snap_pkt(m_spkt), .o_snap_byte(m_sbyte), .o_snap_err(m_serr),
        .o_snap_vld(m_svld), .o_ovf(m_ovf)
    );

    dcmac_axis_stat_cnt #(.NUM_ID(2), .CNT_W(16), .SATURATE(1'b0), .REGISTER_INPUT(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .i_vld(w_vld), .i_id(w_id), .i_eop(w_eop), .i_err(w_err),
        .i_size(w_size), .i_clear(w_clear), .i_snap(w_snap),
        .o_pkt_cnt(a_pkt), .o_byte_cnt(a_byte), .o_err_cnt(a_errc),
        .o_snap_pkt(a_spkt), .o_snap_byte(a_sbyte), .o_snap_err(a_serr),
        .o_snap_vld(a_svld), .o_ovf(a_ovf)
    );

    dcmac_axis_stat_cnt #(.NUM_ID(2), .CNT_W(16), .SATURATE(1'b1), .REGISTER_INPUT(1'b0)) u_sat (
        .clk(clk), .rst(rst), .i_vld(w_vld), .i_id(w_id), .i_eop(w_eop), .i_err(w_err),
        .i_size(w_size), .i_clear(w_clear), .i_snap(w_snap),
        .o_pkt_cnt(s_pkt), .o_byte_cnt(s_byte), .o_err_cnt(s_errc),
        .o_snap_pkt(s_spkt), .o_snap_byte(s_sbyte), .o_snap_err(s_serr),
        .o_snap_vld(s_svld), .o_ovf(s_ovf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        m_vld = 1'b0; m_id = '0; m_eop = '0; m_err = '0; m_size = '0; m_clear = '0; m_snap = '0;
        w_vld = 1'b0; w_id = '0; w_eop = '0; w_err = '0; w_size = '0; w_clear = '0; w_snap = '0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_pkt",   64'(|m_pkt),  64'd0);
        check("rst_byte",  64'(|m_byte), 64'd0);
        check("rst_svld",  64'(|m_svld), 64'd0);
        check("rst_ovf",   64'(|m_ovf),  64'd0);
        check("rst_aux",   64'(|{a_byte, s_byte, a_ovf, s_ovf}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // four beats on id 2, eop=101 err=100 size=64
        m_vld = 1'b1; m_id = 3'd2; m_eop = 3'b101; m_err = 3'b100; m_size = 8'd64;
        @(negedge clk);
        @(negedge clk);
        check("t1_lat_pre", m_pkt[2], 64'd0);
        @(negedge clk);
        check("t1_lat_pkt",  m_pkt[2],  64'd2);
        check("t1_lat_byte", m_byte[2], 64'd64);
        check("t1_lat_err",  m_errc[2], 64'd1);
        @(negedge clk);
        m_vld = 1'b0;
        repeat (3) @(negedge clk);
        check("t1_pkt",  m_pkt[2],  64'd8);
        check("t1_byte", m_byte[2], 64'd256);
        check("t1_err",  m_errc[2], 64'd4);
        for (int i = 0; i < 6; i++) begin
            if (i != 2) check($sformatf("t1_other_%0d", i), m_pkt[i] | m_byte[i] | m_errc[i], 64'd0);
        end

        // out-of-range id, then valid low with eop set
        m_vld = 1'b1; m_id = 3'd7; m_eop = 3'b111; m_err = 3'b111; m_size = 8'd255;
        repeat (2) @(negedge clk);
        m_vld = 1'b0; m_id = 3'd2;
        repeat (5) @(negedge clk);
        check("t2_pkt",  m_pkt[2],  64'd8);
        check("t2_byte", m_byte[2], 64'd256);
        check("t2_err",  m_errc[2], 64'd4);
        for (int i = 0; i < 6; i++) begin
            if (i != 2) check($sformatf("t2_other_%0d", i), m_pkt[i] | m_byte[i] | m_errc[i], 64'd0);
        end
        check("t2_ovf", 64'(m_ovf), 64'd0);

        // snapshot on id 1 during continuous beats (10 beats total)
        m_id = 3'd1; m_eop = 3'b001; m_err = 3'b000; m_size = 8'd10; m_vld = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (c == 5) m_snap = 6'b000010;
            if (c == 6) begin
                m_snap = 6'b000000;
                check("t5_svld_pre", 64'(m_svld[1]), 64'd0);
            end
            if (c == 7) begin
                check("t5_svld",   64'(m_svld[1]), 64'd1);
                check("t5_spkt",   m_spkt[1],  64'd4);
                check("t5_sbyte",  m_sbyte[1], 64'd40);
                check("t5_live_p", m_pkt[1],   64'd1);
                check("t5_live_b", m_byte[1],  64'd10);
            end
            if (c == 8) begin
                check("t5_svld_post", 64'(m_svld[1]), 64'd0);
                check("t5_live_p2",   m_pkt[1],       64'd2);
            end
            if (c == 10) m_vld = 1'b0;
        end
        check("t5_final_p", m_pkt[1],  64'd6);
        check("t5_final_b", m_byte[1], 64'd60);
        check("t5_total",   m_spkt[1] + m_pkt[1], 64'd10);
        check("t5_serr",    m_serr[1], 64'd0);
        check("t5_ovf",     64'(m_ovf[1]), 64'd0);

        // clear edge on id 0 with concurrent traffic, clear then held high
        m_id = 3'd0; m_eop = 3'b011; m_err = 3'b000; m_size = 8'd20; m_vld = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 4) m_clear = 6'b000001;
            if (c == 5) begin
                check("t6_pre_p", m_pkt[0],  64'd6);
                check("t6_pre_b", m_byte[0], 64'd60);
            end
            if (c == 6) begin
                check("t6_clr_p", m_pkt[0],  64'd2);
                check("t6_clr_b", m_byte[0], 64'd20);
            end
            if (c == 7) check("t6_next_p", m_pkt[0], 64'd4);
            if (c == 9) m_vld = 1'b0;
        end
        check("t6_final_p", m_pkt[0],  64'd12);
        check("t6_final_b", m_byte[0], 64'd120);
        m_vld = 1'b1;
        @(negedge clk);
        m_vld = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_held_p", m_pkt[0],  64'd14);
        check("t6_held_b", m_byte[0], 64'd140);
        check("t6_ovf",    64'(m_ovf[0]), 64'd0);
        m_clear = 6'b000000;

        // preload 16-bit byte counters to 0xFFF0 (273 x 240)
        w_id = 1'b0; w_eop = 3'b001; w_err = 3'b000; w_size = 8'd240; w_vld = 1'b1;
        repeat (273) @(negedge clk);
        w_vld = 1'b0;
        repeat (4) @(negedge clk);
        check("w_pre_byte", a_byte[0], 64'hFFF0);
        check("s_pre_byte", s_byte[0], 64'hFFF0);
        check("w_pre_ovf",  64'(a_ovf[0]), 64'd0);

        // one beat of 32 bytes: wrap vs saturate, differing latency
        w_size = 8'd32; w_vld = 1'b1;
        @(negedge clk);
        w_vld = 1'b0;
        check("s_lat_pre", s_byte[0], 64'hFFF0);
        @(negedge clk);
        check("s_sat_byte", s_byte[0], 64'hFFFF);
        check("s_sat_ovf",  64'(s_ovf[0]), 64'd1);
        check("w_lat_pre",  a_byte[0], 64'hFFF0);
        @(negedge clk);
        check("w_wrap_byte", a_byte[0], 64'h0010);
        check("w_wrap_ovf",  64'(a_ovf[0]), 64'd1);

        // further beats: wrap keeps counting, saturate holds, overflow sticky
        w_size = 8'd100; w_vld = 1'b1;
        repeat (3) @(negedge clk);
        w_vld = 1'b0;
        repeat (4) @(negedge clk);
        check("w_more_byte", a_byte[0], 64'h013C);
        check("w_sticky",    64'(a_ovf[0]), 64'd1);
        check("s_hold_byte", s_byte[0], 64'hFFFF);
        check("s_sticky",    64'(s_ovf[0]), 64'd1);
        check("w_pkt",       a_pkt[0], 64'd277);
        check("s_pkt",       s_pkt[0], 64'd277);

        // clear removes counts and overflow flag
        w_clear = 2'b01;
        repeat (4) @(negedge clk);
        check("w_clr_byte", a_byte[0], 64'd0);
        check("w_clr_ovf",  64'(a_ovf[0]), 64'd0);
        check("s_clr_byte", s_byte[0], 64'd0);
        check("s_clr_ovf",  64'(s_ovf[0]), 64'd0);
        w_clear = 2'b00;

        // reset in the middle of traffic, then first beat after reset
        m_id = 3'd4; m_eop = 3'b001; m_err = 3'b000; m_size = 8'd7; m_vld = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mr_pkt",  64'(|m_pkt),  64'd0);
        check("mr_byte", 64'(|m_byte), 64'd0);
        check("mr_snap", 64'(|{m_spkt, m_sbyte, m_serr}), 64'd0);
        check("mr_flag", 64'(|{m_svld, m_ovf}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        m_vld = 1'b0;
        @(negedge clk);
        check("mr_lat_pre", m_pkt[4], 64'd0);
        @(negedge clk);
        check("mr_first_p", m_pkt[4],  64'd1);
        check("mr_first_b", m_byte[4], 64'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
